net_bus_rx4: RTL and testbench

- Receive-side counterpart of the 4-way NetBus transmit fan-out.
- Merges four NetBus write streams (RDATA0..3 / RVALID0..3 / RREADY0..3) into one NetBus stream (DATA / VALID / READY).
- Arbitration is round-robin and frame-locked, so a frame is never interleaved with another port's frame.
- One registered output stage; single clock domain.

---
 rtl/net_bus_pkg.sv | 16 +
 rtl/net_bus_rr_arb4.sv | 27 ++
 rtl/net_bus_rx4.sv | 103 ++++++++++
 tb/tb_net_bus_rx4.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_bus_pkg.sv
// Shared definitions for the NetBus receive-side merge: port count, word width helper,
// and the frame-lock FSM state encoding.
package net_bus_pkg;

    localparam int NB_PORTS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } nb_state_t;

    function automatic int nb_width(input int data_width);
        return data_width * 9 + 14;
    endfunction

endpackage

// File: rtl/net_bus_rr_arb4.sv
// Combinational 4-way round-robin picker: searches upward from last_ptr+1 with wrap
// and returns the first requesting port.
module net_bus_rr_arb4
    import net_bus_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = 2'd0;
        cand = 2'd0;
        for (int k = 1; k <= NB_PORTS; k++) begin
            cand = last_ptr + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/net_bus_rx4.sv
// Merges four NetBus streams into one with frame-locked round-robin arbitration
// and a single registered output stage.
//
// state   | meaning
// ST_IDLE | between frames; round-robin picks the next requesting port
// ST_LOCK | mid-frame; only the granted port is served until its LAST beat
module net_bus_rx4
    import net_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int LAST_BIT   = DATA_WIDTH * 9 + 13
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [nb_width(DATA_WIDTH)-1:0]  RDATA0,
    input  logic                             RVALID0,
    output logic                             RREADY0,
    input  logic [nb_width(DATA_WIDTH)-1:0]  RDATA1,
    input  logic                             RVALID1,
    output logic                             RREADY1,
    input  logic [nb_width(DATA_WIDTH)-1:0]  RDATA2,
    input  logic                             RVALID2,
    output logic                             RREADY2,
    input  logic [nb_width(DATA_WIDTH)-1:0]  RDATA3,
    input  logic                             RVALID3,
    output logic                             RREADY3,
    output logic [nb_width(DATA_WIDTH)-1:0]  DATA,
    output logic                             VALID,
    input  logic                             READY
);

    localparam int W = nb_width(DATA_WIDTH);

    nb_state_t  state;
    logic [1:0] last_ptr;
    logic [1:0] grant;

    logic [3:0]   req;
    logic         arb_any;
    logic [1:0]   arb_idx;
    logic         slot_free;
    logic         rdy_en;
    logic [1:0]   sel;
    logic [3:0]   rready;
    logic         take;
    logic [W-1:0] word;

    assign req = {RVALID3, RVALID2, RVALID1, RVALID0};

    net_bus_rr_arb4 u_arb (
        .req      (req),
        .last_ptr (last_ptr),
        .any      (arb_any),
        .idx      (arb_idx)
    );

    assign slot_free = !VALID || READY;
    assign sel       = (state == ST_LOCK) ? grant : arb_idx;
    // In LOCK the granted port keeps its ready even while its valid is low.
    assign rdy_en    = (state == ST_LOCK) ? 1'b1 : arb_any;
    assign rready    = (rdy_en && slot_free && !RST) ? (4'b0001 << sel) : 4'b0000;
    assign take      = |(rready & req);

    assign RREADY0 = rready[0];
    assign RREADY1 = rready[1];
    assign RREADY2 = rready[2];
    assign RREADY3 = rready[3];

    always_comb begin
        word = RDATA0;
        case (sel)
            2'd1:    word = RDATA1;
            2'd2:    word = RDATA2;
            2'd3:    word = RDATA3;
            default: word = RDATA0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            last_ptr <= 2'd3;
            grant    <= 2'd0;
            VALID    <= 1'b0;
            DATA     <= '0;
        end else begin
            if (take) begin
                DATA  <= word;
                VALID <= 1'b1;
                if (word[LAST_BIT]) begin
                    state    <= ST_IDLE;
                    last_ptr <= sel;
                end else begin
                    state <= ST_LOCK;
                    grant <= sel;
                end
            end else if (READY) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_net_bus_rx4.sv
// Self-checking bench for net_bus_rx4: directed scenarios plus random traffic against
// a cycle-level reference model of the merge (owner port / round-robin pointer / output slot).
module tb_net_bus_rx4;
    import net_bus_pkg::*;

    localparam int DW = 4;
    localparam int W  = nb_width(DW);
    localparam int LB = DW * 9 + 13;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         READY = 1'b0;
    logic [W-1:0] rdata_i [4];
    logic [3:0]   rvalid_i;
    logic [3:0]   rready_o;
    logic [W-1:0] DATA;
    logic         VALID;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int           m_owner;
    int           m_last;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_acc;

    int           obs_acc;
    logic [3:0]   obs_rdy;
    logic         obs_valid;
    int           acc_log [$];
    logic [W-1:0] deliv_q [$];
    logic [W-1:0] sent_q [$];
    int           deliv_cnt;
    int           rem [4];

    net_bus_rx4 #(.DATA_WIDTH(DW)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RDATA0  (rdata_i[0]),
        .RVALID0 (rvalid_i[0]),
        .RREADY0 (rready_o[0]),
        .RDATA1  (rdata_i[1]),
        .RVALID1 (rvalid_i[1]),
        .RREADY1 (rready_o[1]),
        .RDATA2  (rdata_i[2]),
        .RVALID2 (rvalid_i[2]),
        .RREADY2 (rready_o[2]),
        .RDATA3  (rdata_i[3]),
        .RVALID3 (rvalid_i[3]),
        .RREADY3 (rready_o[3]),
        .DATA    (DATA),
        .VALID   (VALID),
        .READY   (READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit last);
        logic [W-1:0] w;
        w     = W'({$urandom, $urandom});
        w[LB] = last;
        return w;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    // Called at a negedge with inputs already driven; ends at the next negedge.
    task automatic step();
        logic [3:0] er;
        int         p;
        bit         slot;
        #1;
        er = 4'b0000;
        if (!RST) begin
            slot = !m_valid || READY;
            p = -1;
            if (m_owner >= 0) p = m_owner;
            else
                for (int k = 1; k <= 4; k++)
                    if (p < 0 && rvalid_i[(m_last + k) % 4]) p = (m_last + k) % 4;
            if (p >= 0) er[p] = slot;
        end
        chk("rready", 64'(rready_o), 64'(er));
        chk("valid", 64'(VALID), 64'(m_valid));
        chk("data", 64'(DATA), 64'(m_data));
        obs_rdy   = rready_o;
        obs_valid = VALID;
        obs_acc   = -1;
        for (int i = 0; i < 4; i++) if (rready_o[i] && rvalid_i[i]) obs_acc = i;
        if (obs_acc >= 0) acc_log.push_back(obs_acc);
        if (VALID && READY) begin
            deliv_q.push_back(DATA);
            deliv_cnt++;
        end
        m_acc = -1;
        for (int i = 0; i < 4; i++) if (er[i] && rvalid_i[i]) m_acc = i;
        @(posedge CLK);
        if (RST) model_reset();
        else if (m_acc >= 0) begin
            m_data  = rdata_i[m_acc];
            m_valid = 1'b1;
            if (rdata_i[m_acc][LB]) begin
                m_owner = -1;
                m_last  = m_acc;
            end else begin
                m_owner = m_acc;
            end
        end else if (READY) begin
            m_valid = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic quiet(input int n);
        rvalid_i = 4'b0000;
        READY    = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_until(input int p, input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (m_acc == p) got = 1'b1;
        end
        chk(tag, 64'(got), 64'd1);
    endtask

    initial begin
        int exp_fair [6];
        int nb;

        exp_fair = '{0, 1, 2, 3, 0, 1};
        m_acc    = -1;
        deliv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            rdata_i[i] = mk(1'b1);
            rem[i]     = 0;
        end
        rvalid_i = 4'b1111;
        READY    = 1'b1;
        RST      = 1'b1;
        @(posedge CLK);
        model_reset();
        @(negedge CLK);

        // reset held with all ports requesting, then round-robin fairness
        repeat (2) step();
        RST = 1'b0;
        acc_log.delete();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c > 0) chk("fair_valid", 64'(obs_valid), 64'd1);
            if (m_acc >= 0) rdata_i[m_acc] = mk(1'b1);
        end
        chk("fair_cnt", 64'(acc_log.size()), 64'd6);
        if (acc_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk("fair_seq", 64'(acc_log[i]), 64'(exp_fair[i]));

        // frame lock: port 2 three-beat frame while port 1 keeps requesting
        quiet(2);
        rvalid_i[1] = 1'b1;
        rdata_i[1]  = mk(1'b1);
        send_until(1, "lock_pre");
        rdata_i[1]  = mk(1'b1);
        rvalid_i[2] = 1'b1;
        rdata_i[2]  = mk(1'b0);
        acc_log.delete();
        nb = 0;
        for (int c = 0; c < 10 && nb < 3; c++) begin
            step();
            chk("lock_rdy1", 64'(obs_rdy[1]), 64'd0);
            if (m_acc == 2) begin
                nb++;
                rdata_i[2] = mk(nb == 2);
                if (nb == 3) rvalid_i[2] = 1'b0;
            end
        end
        chk("lock_beats", 64'(nb), 64'd3);
        step();
        chk("lock_cnt", 64'(acc_log.size()), 64'd4);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 3; i++) chk("lock_port", 64'(acc_log[i]), 64'd2);
            chk("lock_next", 64'(acc_log[3]), 64'd1);
        end

        // backpressure mid-frame: 8-word frame on port 0, READY low for 4 cycles
        quiet(2);
        deliv_q.delete();
        sent_q.delete();
        deliv_cnt   = 0;
        nb          = 0;
        rvalid_i[0] = 1'b1;
        rdata_i[0]  = mk(1'b0);
        sent_q.push_back(rdata_i[0]);
        for (int c = 0; c < 40 && deliv_cnt < 8; c++) begin
            READY = !(c >= 2 && c < 6);
            step();
            if (m_acc == 0) begin
                nb++;
                if (nb < 8) begin
                    rdata_i[0] = mk(nb == 7);
                    sent_q.push_back(rdata_i[0]);
                end else begin
                    rvalid_i[0] = 1'b0;
                end
            end
        end
        chk("bp_cnt", 64'(deliv_cnt), 64'd8);
        if (deliv_q.size() == 8 && sent_q.size() == 8)
            for (int i = 0; i < 8; i++) chk("bp_word", 64'(deliv_q[i]), 64'(sent_q[i]));

        // bubble inside a locked frame on port 3
        quiet(2);
        rvalid_i[3] = 1'b1;
        rdata_i[3]  = mk(1'b0);
        send_until(3, "bub_b1");
        rvalid_i[3] = 1'b0;
        rvalid_i[0] = 1'b1;
        rdata_i[0]  = mk(1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bub_rdy0", 64'(obs_rdy[0]), 64'd0);
        end
        chk("bub_drain", 64'(obs_valid), 64'd0);
        rvalid_i[3] = 1'b1;
        rdata_i[3]  = mk(1'b0);
        send_until(3, "bub_b2");
        rdata_i[3]  = mk(1'b1);
        send_until(3, "bub_b3");
        rvalid_i[3] = 1'b0;
        step();
        chk("bub_next", 64'(obs_acc), 64'd0);

        // reset in the middle of a 4-beat frame on port 1
        quiet(2);
        rvalid_i[1] = 1'b1;
        rdata_i[1]  = mk(1'b0);
        send_until(1, "rst_b1");
        rdata_i[1]  = mk(1'b0);
        rvalid_i[0] = 1'b1;
        rdata_i[0]  = mk(1'b1);
        RST = 1'b1;
        step();
        chk("rst_rdy", 64'(obs_rdy), 64'd0);
        RST = 1'b0;
        step();
        chk("rst_valid", 64'(obs_valid), 64'd0);
        chk("rst_win", 64'(obs_acc), 64'd0);

        // random traffic with variable frame lengths, gaps, backpressure and rare resets
        quiet(2);
        m_acc = -1;
        for (int c = 0; c < 3000; c++) begin
            RST   = ($urandom_range(0, 199) == 0);
            READY = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 4; p++) begin
                if (!(rvalid_i[p] && m_acc != p)) begin
                    if (m_acc == p) rem[p]--;
                    if (rem[p] <= 0) rem[p] = int'($urandom_range(1, 4));
                    rvalid_i[p] = ($urandom_range(0, 9) < 7);
                    rdata_i[p]  = mk(rem[p] == 1);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
